program_loader: RTL and testbench

Writer-side front end for the core's 32-word instruction ROM: accepts a program image as a valid/ready word stream, writes it into the instruction memory via a registered write port, pads unused words with NOP, and holds the CPU in reset until the image is complete. It sits between the host/debug link and the `initial_instructions` storage. It releases `cpu_reset` only after every ROM word has been written.

---
 rtl/program_loader.sv | 157 +++++++++++++++
 tb/tb_program_loader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// program_loader: writer-side front end for the core's instruction ROM.
// Accepts a header/payload(/checksum) word stream over valid/ready, writes the
// payload into ROM through a registered write port, pads the remainder with
// NOP, and holds the CPU in reset until the whole ROM has been written.
// Optional feature macro: LOADER_CHECKSUM_EN adds a trailing checksum word
// that must equal the 32-bit sum of the payload words.
module program_loader #(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_data,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          cpu_reset,
  output logic          done,
  output logic          error
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_HEADER, S_LOAD, S_FILL, S_CHECK, S_DONE, S_ERROR
  } state_t;
  localparam state_t POST_STATE = S_CHECK;
`else
  typedef enum logic [2:0] {
    S_HEADER, S_LOAD, S_FILL, S_DONE, S_ERROR
  } state_t;
  localparam state_t POST_STATE = S_DONE;
`endif

  localparam logic [31:0] NOP     = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0] LAST_W  = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] ONE_W   = (AW+1)'(1);

  state_t        state, next_state;
  // idx/count are one bit wider than the address so count == DEPTH fits.
  logic [AW:0]   idx, next_idx;
  logic [AW:0]   count, next_count;
  logic          next_we;
  logic [AW-1:0] next_addr;
  logic [31:0]   next_wdata;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]   sum, next_sum;
`endif

  logic        accept;
  logic [15:0] hdr_count;

  assign accept    = in_valid && in_ready;
  assign hdr_count = in_data[15:0];

  // Next-state, index and write-port decode.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
    next_state = state;
    next_idx   = idx;
    next_count = count;
    next_we    = 1'b0;
    next_addr  = imem_addr;
    next_wdata = imem_wdata;
`ifdef LOADER_CHECKSUM_EN
    next_sum   = sum;
`endif
    case (state)
      S_HEADER: begin
        if (accept) begin
          if (hdr_count == 16'd0 || hdr_count > 16'(DEPTH)) begin
            next_state = S_ERROR;
          end else begin
            next_count = hdr_count[AW:0];
            next_idx   = '0;
            next_state = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (accept) begin
          next_we    = 1'b1;
          next_addr  = idx[AW-1:0];
          next_wdata = in_data;
          next_idx   = idx + ONE_W;
`ifdef LOADER_CHECKSUM_EN
          next_sum   = sum + in_data;
`endif
          if (idx == count - ONE_W) begin
            next_state = (count < DEPTH_W) ? S_FILL : POST_STATE;
          end
        end
      end
      S_FILL: begin
        next_we    = 1'b1;
        next_addr  = idx[AW-1:0];
        next_wdata = NOP;
        next_idx   = idx + ONE_W;
        if (idx == LAST_W) begin
          next_state = POST_STATE;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (accept) begin
          next_state = (in_data == sum) ? S_DONE : S_ERROR;
        end
      end
`endif
      default: ;  // DONE and ERROR are terminal until reset
    endcase
  end

  // State, index and registered outputs; synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (reset) begin
      state      <= S_HEADER;
      idx        <= '0;
      count      <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum        <= '0;
`endif
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_reset  <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state      <= next_state;
      idx        <= next_idx;
      count      <= next_count;
`ifdef LOADER_CHECKSUM_EN
      sum        <= next_sum;
`endif
      imem_we    <= next_we;
      imem_addr  <= next_addr;
      imem_wdata <= next_wdata;
`ifdef LOADER_CHECKSUM_EN
      in_ready   <= (next_state == S_HEADER) || (next_state == S_LOAD) ||
                    (next_state == S_CHECK);
`else
      in_ready   <= (next_state == S_HEADER) || (next_state == S_LOAD);
`endif
      // Status follows the state one cycle late, so done rises the cycle
      // after the final write strobe.
      cpu_reset  <= (state != S_DONE);
      done       <= (state == S_DONE);
      error      <= (state == S_ERROR);
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed images from the test plan
// plus randomized images, all checked every cycle against a transaction-level
// model (accepted-word and issued-write counts), with a few literal pins.
module tb_program_loader;

  localparam int          DEPTH = 32;
  localparam int          AW    = $clog2(DEPTH);
  localparam logic [31:0] NOP   = 32'h0000_0013;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_data;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_reset;
  logic          done;
  logic          error;

  program_loader #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_reset(cpu_reset), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Stimulus image and driver controls.
  logic [31:0] stream[$];
  int          vpct = 100;
  bit          pat  = 1'b0;

  // Model state: counts of accepted words and issued writes.
  int          n_acc, n_wr, cnt, term;
  bit          hdr_ok, started;
  logic [31:0] msum;
  bit          e_ready, e_we, e_done, e_err, e_rst_vals;
  int          e_addr;
  logic [31:0] e_data;
  logic [31:0] rom [DEPTH];

  // Transaction-level model: sees each edge's handshake and predicts outputs for the following cycle.
  always @(posedge clk) begin
    bit acc;
    acc     = in_valid && in_ready;
    started = 1'b1;
    e_we    = 1'b0;
    if (reset) begin
      n_acc = 0; n_wr = 0; cnt = 0; term = 0; hdr_ok = 1'b0; msum = '0;
      e_ready = 1'b0; e_done = 1'b0; e_err = 1'b0; e_rst_vals = 1'b1;
    end else begin
      e_rst_vals = 1'b0;
      if (term == 1) e_done = 1'b1;
      if (term == 2) e_err  = 1'b1;
      if (acc && e_ready) begin
        if (n_acc == 0) begin
          cnt    = int'(in_data[15:0]);
          hdr_ok = (cnt != 0) && (cnt <= DEPTH);
          if (!hdr_ok) term = 2;
        end else if (n_acc <= cnt) begin
          e_we = 1'b1; e_addr = n_wr; e_data = in_data;
          n_wr++;
          msum = msum + in_data;
        end else begin
          term = (in_data == msum) ? 1 : 2;
        end
        n_acc++;
      end else if (hdr_ok && n_acc == cnt + 1 && n_wr < DEPTH) begin
        e_we = 1'b1; e_addr = n_wr; e_data = NOP;
        n_wr++;
      end
      if (!CHK && hdr_ok && e_we && n_wr == DEPTH && term == 0) term = 1;
      e_ready = (term == 0) &&
                ((n_acc == 0) || (hdr_ok && n_acc <= cnt) ||
                 (CHK && hdr_ok && n_acc == cnt + 1 && n_wr == DEPTH));
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      check("in_ready",  {31'b0, in_ready},  {31'b0, e_ready});
      check("imem_we",   {31'b0, imem_we},   {31'b0, e_we});
      check("done",      {31'b0, done},      {31'b0, e_done});
      check("error",     {31'b0, error},     {31'b0, e_err});
      check("cpu_reset", {31'b0, cpu_reset}, {31'b0, !e_done});
      if (e_we) begin
        check("imem_addr",  32'(imem_addr), 32'(e_addr));
        check("imem_wdata", imem_wdata, e_data);
      end
      if (e_rst_vals) begin
        check("rst_addr",  32'(imem_addr), 32'd0);
        check("rst_wdata", imem_wdata,     32'd0);
      end
      if (imem_we) rom[imem_addr] = imem_wdata;
    end
  end

  // Driver: presents stream[n_acc]; once the image is exhausted, holds junk with in_valid=1.
  initial begin
    int cyc;
    cyc      = 0;
    in_valid = 1'b0;
    in_data  = '0;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      if (n_acc < stream.size()) begin
        in_data  = stream[n_acc];
        in_valid = pat ? ((cyc % 4 == 0) || (cyc % 4 == 3))
                       : ($urandom_range(99) < vpct);
      end else begin
        in_data  = $urandom;
        in_valid = 1'b1;
      end
    end
  end

  task automatic add_checksum(input bit good);
    logic [31:0] s;
    s = '0;
    for (int i = 1; i < stream.size(); i++) s = s + stream[i];
    if (CHK) stream.push_back(good ? s : s + 32'd1);
  endtask

  // Assumes the caller sits just after an edge: one reset cycle, then run to completion.
  task automatic do_test(input int budget);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < budget && !(e_done || e_err); i++) begin
      @(posedge clk); #1;
    end
    if (!(e_done || e_err)) begin
      checks++;
      failures++;
      $display("FAIL timeout actual=not_finished expected=done_or_error t=%0t", $time);
    end
    repeat (12) @(posedge clk);
    #1;
  endtask

  initial begin
    int c;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Full image, words 0x100+i, valid held high.
    vpct = 100;
    stream = {32'h0000_0020};
    for (int i = 0; i < DEPTH; i++) stream.push_back(32'h100 + 32'(i));
    add_checksum(1'b1);
    do_test(500);
    check("full_rom0",  rom[0],  32'h0000_0100);
    check("full_rom31", rom[31], 32'h0000_011F);
    check("full_done",  {31'b0, done}, 32'd1);

    // Short image A,B,C then NOP fill; upper header bits ignored.
    stream = {32'hBEEF_0003, 32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};
    add_checksum(1'b1);
    do_test(500);
    check("short_rom2",  rom[2],  32'hCCCC_0003);
    check("short_rom3",  rom[3],  32'h0000_0013);
    check("short_rom31", rom[31], 32'h0000_0013);
    check("short_writes", 32'(n_wr), 32'd32);

    // Bad headers: 0 and DEPTH+1.
    stream = {32'h0000_0000};
    do_test(100);
    check("bad0_error", {31'b0, error},     32'd1);
    check("bad0_cpu",   {31'b0, cpu_reset}, 32'd1);
    stream = {32'h0000_0021};
    do_test(100);
    check("bad33_error", {31'b0, error},    32'd1);
    check("bad33_ready", {31'b0, in_ready}, 32'd0);

    // Backpressure: valid pattern 1,0,0,1.
    pat = 1'b1;
    stream = {32'h0000_0002, 32'h1234_5678, 32'h9ABC_DEF0};
    add_checksum(1'b1);
    do_test(500);
    pat = 1'b0;
    check("bp_rom1", rom[1], 32'h9ABC_DEF0);

`ifdef LOADER_CHECKSUM_EN
    // Checksum good (12) and bad (13).
    stream = {32'h0000_0002, 32'd5, 32'd7, 32'd12};
    do_test(500);
    check("chk_good_done", {31'b0, done}, 32'd1);
    stream = {32'h0000_0002, 32'd5, 32'd7, 32'd13};
    do_test(500);
    check("chk_bad_error", {31'b0, error},     32'd1);
    check("chk_bad_cpu",   {31'b0, cpu_reset}, 32'd1);
`endif

    // Reset mid-load after header 4 and two words, then reload with header 1.
    stream = {32'h0000_0004, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 200 && n_acc < 3; i++) begin
      @(posedge clk); #1;
    end
    if (n_acc < 3) begin
      checks++;
      failures++;
      $display("FAIL midload_timeout actual=%0d expected=3 t=%0t", n_acc, $time);
    end
    stream = {32'h0000_0001, 32'h5A5A_A5A5};
    add_checksum(1'b1);
    do_test(500);
    check("mid_rom0", rom[0], 32'h5A5A_A5A5);
    check("mid_rom1", rom[1], 32'h0000_0013);
    check("mid_done", {31'b0, done}, 32'd1);

    // Randomized images.
    for (int t = 0; t < 30; t++) begin
      vpct = int'($urandom_range(100, 30));
      case ($urandom_range(9))
        0:       c = 0;
        1:       c = DEPTH + 1 + int'($urandom_range(1000));
        2:       c = DEPTH;
        default: c = int'($urandom_range(DEPTH, 1));
      endcase
      stream = {{16'($urandom), 16'(c)}};
      if (c >= 1 && c <= DEPTH) begin
        for (int i = 0; i < c; i++) stream.push_back($urandom);
        add_checksum($urandom_range(9) < 7);
      end
      do_test(2000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
